// File: rtl/tmds_pkg.sv
// Shared TMDS receive definitions: control tokens, alignment FSM states and
// the data-symbol decode function.
package tmds_pkg;

  localparam logic [9:0] TOK_C00 = 10'h354;
  localparam logic [9:0] TOK_C01 = 10'h0AB;
  localparam logic [9:0] TOK_C10 = 10'h154;
  localparam logic [9:0] TOK_C11 = 10'h2AB;

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} align_state_e;

  typedef struct packed {
    logic       is_tok;
    logic [1:0] c;
  } tok_info_t;

  function automatic tok_info_t tmds_classify(input logic [9:0] w);
    tok_info_t t;
    t = '0;
    case (w)
      TOK_C00: begin t.is_tok = 1'b1; t.c = 2'b00; end
      TOK_C01: begin t.is_tok = 1'b1; t.c = 2'b01; end
      TOK_C10: begin t.is_tok = 1'b1; t.c = 2'b10; end
      TOK_C11: begin t.is_tok = 1'b1; t.c = 2'b11; end
      default: t = '0;
    endcase
    return t;
  endfunction

  // bit9 undoes the DC-balance inversion, bit8 selects XOR vs XNOR chaining.
  function automatic logic [7:0] tmds_decode(input logic [9:0] w);
    logic [7:0] q;
    logic [7:0] d;
    q    = w[9] ? ~w[7:0] : w[7:0];
    d    = '0;
    d[0] = q[0];
    for (int i = 1; i < 8; i++)
      d[i] = w[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

endpackage

// File: rtl/tmds_word_align.sv
// Word alignment for a TMDS lane: 20-bit sliding window, HUNT/LOCKED FSM
// with slip and loss timers. Optional lock-loss counter: TMDS_DECODER_STATS_EN.
module tmds_word_align
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT     = 8,
  parameter int SLIP_WAIT    = 64,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] rx_word_i,
  output logic [9:0] word_o,
  output tok_info_t  tok_o,
  output logic       lock_next_o,
  output logic       locked_o,
`ifdef TMDS_DECODER_STATS_EN
  output logic [7:0] lock_loss_cnt_o,
`endif
  output logic [3:0] bit_offset_o
);

  localparam int TCW = $clog2(LOCK_CNT + 1);
  localparam int SW  = $clog2(SLIP_WAIT + 1);
  localparam int LW  = $clog2(LOSS_TIMEOUT + 1);

  logic [9:0]   cur_q, prev_q, word_q;
  tok_info_t    tok_q;
  align_state_e state_q, state_d;
  logic [3:0]   off_q, off_d;
  logic [TCW-1:0] tok_cnt_q, tok_cnt_d;
  logic [SW-1:0]  slip_q, slip_d;
  logic [LW-1:0]  loss_q, loss_d;

  logic [19:0] buf_w;
  logic [9:0]  aligned;
  tok_info_t   tok;

  // Previous word holds the earlier bits, so it occupies the low half.
  assign buf_w   = {cur_q, prev_q};
  assign aligned = 10'(buf_w >> off_q);
  assign tok     = tmds_classify(aligned);

  always_comb begin
    state_d   = state_q;
    off_d     = off_q;
    tok_cnt_d = tok_cnt_q;
    slip_d    = slip_q;
    loss_d    = loss_q;
    unique case (state_q)
      HUNT: begin
        if (!tok.is_tok)                         tok_cnt_d = '0;
        else if (tok_cnt_q != TCW'(LOCK_CNT))    tok_cnt_d = tok_cnt_q + TCW'(1);
        if (slip_q != SW'(SLIP_WAIT))            slip_d    = slip_q + SW'(1);
        // Lock takes priority over a slip landing in the same cycle.
        if (tok.is_tok && tok_cnt_q >= TCW'(LOCK_CNT - 1)) begin
          state_d   = LOCKED;
          tok_cnt_d = '0;
          slip_d    = '0;
          loss_d    = '0;
        end else if (slip_q >= SW'(SLIP_WAIT - 1)) begin
          off_d     = (off_q >= 4'd9) ? 4'd0 : off_q + 4'd1;
          tok_cnt_d = '0;
          slip_d    = '0;
        end
      end
      LOCKED: begin
        if (tok.is_tok) begin
          loss_d = '0;
        end else if (loss_q >= LW'(LOSS_TIMEOUT - 1)) begin
          state_d   = HUNT;
          tok_cnt_d = '0;
          slip_d    = '0;
          loss_d    = '0;
        end else begin
          loss_d = loss_q + LW'(1);
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_q     <= '0;
      prev_q    <= '0;
      word_q    <= '0;
      tok_q     <= '0;
      state_q   <= HUNT;
      off_q     <= '0;
      tok_cnt_q <= '0;
      slip_q    <= '0;
      loss_q    <= '0;
    end else begin
      cur_q     <= rx_word_i;
      prev_q    <= cur_q;
      word_q    <= aligned;
      tok_q     <= tok;
      state_q   <= state_d;
      off_q     <= off_d;
      tok_cnt_q <= tok_cnt_d;
      slip_q    <= slip_d;
      loss_q    <= loss_d;
    end
  end

`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] loss_cnt_q, loss_cnt_d;

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (state_q == LOCKED && state_d == HUNT && loss_cnt_q != 8'hFF)
      loss_cnt_d = loss_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) loss_cnt_q <= '0;
    else       loss_cnt_q <= loss_cnt_d;
  end

  assign lock_loss_cnt_o = loss_cnt_q;
`endif

  assign word_o       = word_q;
  assign tok_o        = tok_q;
  assign lock_next_o  = (state_d == LOCKED);
  assign locked_o     = (state_q == LOCKED);
  assign bit_offset_o = off_q;

endmodule

// File: rtl/tmds_decoder.sv
// TMDS lane decoder: aligner plus decode/output register stage (latency 2).
// Optional lock-loss counter port: TMDS_DECODER_STATS_EN.
module tmds_decoder
  import tmds_pkg::*;
#(
  parameter int LOCK_CNT     = 8,
  parameter int SLIP_WAIT    = 64,
  parameter int LOSS_TIMEOUT = 4096
) (
  input  logic       pixel_clk_i,
  input  logic       rst_i,
  input  logic [9:0] rx_word_i,
  output logic [7:0] data_o,
  output logic       de_o,
  output logic [1:0] c_o,
  output logic       locked_o,
`ifdef TMDS_DECODER_STATS_EN
  output logic [7:0] lock_loss_cnt_o,
`endif
  output logic [3:0] bit_offset_o
);

  logic [9:0] word;
  tok_info_t  tok;
  logic       lock_next;

  tmds_word_align #(
    .LOCK_CNT     (LOCK_CNT),
    .SLIP_WAIT    (SLIP_WAIT),
    .LOSS_TIMEOUT (LOSS_TIMEOUT)
  ) u_align (
    .clk_i           (pixel_clk_i),
    .rst_i           (rst_i),
    .rx_word_i       (rx_word_i),
    .word_o          (word),
    .tok_o           (tok),
    .lock_next_o     (lock_next),
    .locked_o        (locked_o),
`ifdef TMDS_DECODER_STATS_EN
    .lock_loss_cnt_o (lock_loss_cnt_o),
`endif
    .bit_offset_o    (bit_offset_o)
  );

  logic [7:0] data_q, data_d;
  logic       de_q, de_d;
  logic [1:0] c_q, c_d;

  // Gate on the FSM's next state so outputs clear on the same edge locked_o drops.
  always_comb begin
    data_d = data_q;
    de_d   = de_q;
    c_d    = c_q;
    if (!lock_next) begin
      data_d = '0;
      de_d   = 1'b0;
      c_d    = '0;
    end else if (tok.is_tok) begin
      de_d = 1'b0;
      c_d  = tok.c;
    end else begin
      de_d   = 1'b1;
      data_d = tmds_decode(word);
    end
  end

  always_ff @(posedge pixel_clk_i) begin
    if (rst_i) begin
      data_q <= '0;
      de_q   <= 1'b0;
      c_q    <= '0;
    end else begin
      data_q <= data_d;
      de_q   <= de_d;
      c_q    <= c_d;
    end
  end

  assign data_o = data_q;
  assign de_o   = de_q;
  assign c_o    = c_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Scoreboard bench for tmds_decoder: expected bytes are queued at stimulus
// time and popped by a negedge monitor whenever de_o is high.
module tb_tmds_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rx  = '0;
  logic [7:0] data;
  logic       de;
  logic [1:0] c;
  logic       locked;
  logic [3:0] off;
`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] llc;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  bit sb_en = 1'b1;

  tmds_decoder dut (
    .pixel_clk_i     (clk),
    .rst_i           (rst),
    .rx_word_i       (rx),
    .data_o          (data),
    .de_o            (de),
    .c_o             (c),
    .locked_o        (locked),
`ifdef TMDS_DECODER_STATS_EN
    .lock_loss_cnt_o (llc),
`endif
    .bit_offset_o    (off)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] w);
    rx = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles, input bit clr_rx);
    @(negedge clk);
    #1;
    exp_q.delete();
    if (clr_rx) rx = '0;
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Reference TMDS encoder (transition minimisation, bit9 chosen from d[0]).
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    int n1;
    n1 = $countones(d);
    qm = '0;
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    return d[0] ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
  endfunction

  function automatic logic [9:0] rotl10(input logic [9:0] w, input int k);
    logic [19:0] t;
    t = {w, w} << k;
    return t[19:10];
  endfunction

  always @(negedge clk) begin
    if (!locked) begin
      check("unlocked_de", de, 0);
      check("unlocked_data", data, 0);
      check("unlocked_c", c, 0);
    end else if (de && sb_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_data", 1, 0);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("sb_data", data, e);
      end
    end
  end

  // Hand-decoded data symbols: {word, byte}.
  logic [9:0] vec_w [6] = '{10'h100, 10'h000, 10'h155, 10'h055, 10'h1F0, 10'h2FF};
  logic [7:0] vec_d [6] = '{8'h00,   8'hFE,   8'hFF,   8'h01,   8'h10,   8'hFE};

  initial begin
    int drop_at;
    int last_chg;
    logic [3:0] prev_off;
    logic [9:0] rw;

    // Reset state
    do_reset(3, 1'b1);
    check("rst_locked", locked, 0);
    check("rst_off", off, 0);
    check("rst_de", de, 0);
    check("rst_data", data, 0);
    check("rst_c", c, 0);

    // Aligned lock: 8x 0x354 then data 0x100
    for (int i = 0; i < 8; i++) begin
      drive(10'h354);
      check("lock_early", locked, 0);
    end
    exp_q.push_back(vec_d[0]);
    drive(vec_w[0]);
    check("lock_early", locked, 0);
    drive(10'h354);
    check("lock_after_8", locked, 1);
    drive(10'h354);
    check("lat_de_lo", de, 0);
    drive(10'h354);
    check("lat2_de", de, 1);
    check("lat2_data", data, vec_d[0]);

    for (int i = 1; i < 6; i++) begin
      exp_q.push_back(vec_d[i]);
      drive(vec_w[i]);
    end
    repeat (4) drive(10'h354);
    check("q_empty_dir", exp_q.size(), 0);
    repeat (4) drive(10'h2AB);
    check("tok_c11", c, 2'b11);
    check("tok_de", de, 0);
    check("tok_hold_data", data, 8'hFE);
    repeat (4) drive(10'h154);
    check("tok_c10", c, 2'b10);

    // Reset pulse while locked mid-data
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'hFF);
      drive(10'h155);
    end
    check("mid_data_de", de, 1);
    do_reset(1, 1'b0);
    check("rp_locked", locked, 0);
    check("rp_off", off, 0);
    check("rp_de", de, 0);
    check("rp_data", data, 0);
    check("rp_c", c, 0);

    // Broken run: 7 tokens, 1 data, 8 tokens
    do_reset(2, 1'b1);
    for (int i = 0; i < 18; i++) begin
      drive((i == 7) ? 10'h100 : 10'h354);
      check("broken_run_lock", locked, (i >= 17) ? 1 : 0);
    end

    // Data sweep over all bytes with encoder-model words
    do_reset(2, 1'b1);
    repeat (10) drive(10'h354);
    check("sweep_locked", locked, 1);
    for (int b = 0; b < 256; b++) begin
      if (b % 32 == 0) drive(10'h0AB);
      exp_q.push_back(8'(b));
      drive(tmds_enc(8'(b)));
    end
    repeat (5) drive(10'h354);
    check("q_empty_sweep", exp_q.size(), 0);
    check("sweep_still_locked", locked, 1);

    // Rotated stream: offset slips every SLIP_WAIT cycles until lock at 3
    do_reset(2, 1'b1);
    rw = rotl10(10'h0AB, 3);
    last_chg = -1;
    prev_off = 4'd0;
    for (int k = 0; k < 400 && !locked; k++) begin
      drive(rw);
      if (off != prev_off) begin
        if (last_chg >= 0) check("slip_interval", k - last_chg, 64);
        last_chg = k;
        prev_off = off;
      end
    end
    check("rot_locked", locked, 1);
    check("rot_offset", off, 3);
    repeat (3) drive(rw);
    check("rot_c01", c, 2'b01);
    check("rot_de", de, 0);

    // Loss of lock after LOSS_TIMEOUT non-token words
    sb_en = 1'b0;
    drop_at = 0;
    for (int k = 1; k <= 4200; k++) begin
      drive(10'h000);
      if (!locked) begin
        drop_at = k;
        break;
      end
    end
    check("loss_drop_at", drop_at, 4097);
    check("loss_off_kept", off, 3);
`ifdef TMDS_DECODER_STATS_EN
    check("loss_cnt", llc, 1);
`endif
    sb_en = 1'b1;
    do_reset(1, 1'b1);
    check("final_off", off, 0);
`ifdef TMDS_DECODER_STATS_EN
    check("loss_cnt_rst", llc, 0);
`endif

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
